// File: rtl/iodelay_eye_scan_if.sv
// Delay-block link for the IODELAY eye scanner.
// The scanner (master) addresses a channel and tap and strobes the load.
// The delay block (slave) returns delayed data and the expected training bits.
interface iodelay_eye_scan_if #(
    parameter int unsigned NINPUT = 20
) ();
    logic [7:0]        delay_channel;
    logic [4:0]        delay_value;
    logic              delay_update;
    logic [NINPUT-1:0] data_in;
    logic [NINPUT-1:0] expect_in;

    modport master (
        output delay_channel,
        output delay_value,
        output delay_update,
        input  data_in,
        input  expect_in
    );

    modport slave (
        input  delay_channel,
        input  delay_value,
        input  delay_update,
        output data_in,
        output expect_in
    );
endinterface

// File: rtl/iodelay_eye_scan.sv
// IODELAY eye scanner.
// For every channel, each of the 32 taps is loaded, allowed to settle and then sampled against
// the expected training pattern. The centre of the longest error-free tap run is then loaded
// and reported. Optional macro IODELAY_EYE_SCAN_ERRMAP_EN adds the errmap_o port, which exposes
// the per-channel good-tap map alongside each result.
module iodelay_eye_scan #(
    parameter int unsigned NINPUT        = 20,
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned SAMPLE_CYCLES = 256
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               start_i,
    iodelay_eye_scan_if.master dly_io,
    output logic               busy_o,
    output logic               done_o,
    output logic               result_valid_o,
    output logic [7:0]         result_channel_o,
    output logic [4:0]         result_tap_o,
    output logic [5:0]         result_width_o,
`ifdef IODELAY_EYE_SCAN_ERRMAP_EN
    output logic [31:0]        errmap_o,
`endif
    output logic [NINPUT-1:0]  fail_o
);

    typedef enum logic [3:0] {
        StIdle,
        StLoad,
        StSettle,
        StSample,
        StEval,
        StSetCenter,
        StCenterWait,
        StNextCh,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [7:0]        ch_q, ch_d;
    logic [4:0]        tap_q, tap_d;
    logic              err_q, err_d;
    logic [31:0]       map_q, map_d;
    logic [4:0]        value_q, value_d;
    logic              update_q, update_d;
    logic [4:0]        win_tap_q, win_tap_d;
    logic [5:0]        win_len_q, win_len_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              rv_q, rv_d;
    logic [7:0]        res_ch_q, res_ch_d;
    logic [4:0]        res_tap_q, res_tap_d;
    logic [5:0]        res_width_q, res_width_d;
    logic [NINPUT-1:0] fail_q, fail_d;
`ifdef IODELAY_EYE_SCAN_ERRMAP_EN
    logic [31:0]       errmap_q, errmap_d;
`endif

    logic [NINPUT-1:0] diff;
    logic [NINPUT-1:0] ch_sel;
    logic              miss;
    logic [31:0]       eval_map;
    logic [5:0]        run_len, best_len;
    logic [4:0]        run_start, best_start, best_tap;

    assign diff     = dly_io.data_in ^ dly_io.expect_in;
    assign ch_sel   = NINPUT'(1) << ch_q;
    assign miss     = |(diff & ch_sel);
    // Map as it will be once the tap under evaluation is recorded.
    assign eval_map = map_q | (32'(!err_q) << tap_q);

    // Longest run of good taps; strict '>' keeps the lowest start on ties.
    always_comb begin
        run_len    = '0;
        run_start  = '0;
        best_len   = '0;
        best_start = '0;
        for (int i = 0; i < 32; i++) begin
            if (eval_map[i]) begin
                if (run_len == 6'd0) begin
                    run_start = 5'(i);
                end
                run_len = run_len + 6'd1;
                if (run_len > best_len) begin
                    best_len   = run_len;
                    best_start = run_start;
                end
            end else begin
                run_len = '0;
            end
        end
        best_tap = (best_len == 6'd0) ? 5'd0 : best_start + 5'((best_len - 6'd1) >> 1);
    end

    // Next-state and output decode for the scan sequencer.
    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        tap_d       = tap_q;
        err_d       = err_q;
        map_d       = map_q;
        value_d     = value_q;
        win_tap_d   = win_tap_q;
        win_len_d   = win_len_q;
        res_ch_d    = res_ch_q;
        res_tap_d   = res_tap_q;
        res_width_d = res_width_q;
        fail_d      = fail_q;
        done_d      = 1'b0;
        rv_d        = 1'b0;
`ifdef IODELAY_EYE_SCAN_ERRMAP_EN
        errmap_d    = errmap_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StLoad;
                    ch_d    = '0;
                    tap_d   = '0;
                    value_d = '0;
                    map_d   = '0;
                    err_d   = 1'b0;
                    fail_d  = '0;
                end
            end
            StLoad: begin
                if (cnt_q == 16'd1) state_d = StSettle;
            end
            StSettle: begin
                if (cnt_q == 16'(SETTLE_CYCLES - 1)) begin
                    state_d = StSample;
                    err_d   = 1'b0;
                end
            end
            StSample: begin
                if (miss) err_d = 1'b1;
                if (cnt_q == 16'(SAMPLE_CYCLES - 1)) state_d = StEval;
            end
            StEval: begin
                map_d = eval_map;
                if (tap_q == 5'd31) begin
                    state_d   = StSetCenter;
                    value_d   = best_tap;
                    win_tap_d = best_tap;
                    win_len_d = best_len;
                end else begin
                    state_d = StLoad;
                    tap_d   = tap_q + 5'd1;
                    value_d = tap_q + 5'd1;
                end
            end
            StSetCenter: begin
                if (cnt_q == 16'd1) state_d = StCenterWait;
            end
            StCenterWait: begin
                if (cnt_q == 16'(SETTLE_CYCLES - 1)) begin
                    state_d     = StNextCh;
                    rv_d        = 1'b1;
                    res_ch_d    = ch_q;
                    res_tap_d   = win_tap_q;
                    res_width_d = win_len_q;
`ifdef IODELAY_EYE_SCAN_ERRMAP_EN
                    errmap_d    = map_q;
`endif
                    if (win_len_q == 6'd0) fail_d = fail_q | ch_sel;
                end
            end
            StNextCh: begin
                if (ch_q == 8'(NINPUT - 1)) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                end else begin
                    state_d = StLoad;
                    ch_d    = ch_q + 8'd1;
                    tap_d   = '0;
                    value_d = '0;
                    map_d   = '0;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        // Strobe is high exactly while a load state is occupied (2 cycles each).
        update_d = (state_d == StLoad) || (state_d == StSetCenter);
        busy_d   = (state_d != StIdle) && (state_d != StDone);
        cnt_d    = (state_d != state_q) ? 16'd0 : cnt_q + 16'd1;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            ch_q        <= '0;
            tap_q       <= '0;
            err_q       <= 1'b0;
            map_q       <= '0;
            value_q     <= '0;
            update_q    <= 1'b0;
            win_tap_q   <= '0;
            win_len_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rv_q        <= 1'b0;
            res_ch_q    <= '0;
            res_tap_q   <= '0;
            res_width_q <= '0;
            fail_q      <= '0;
`ifdef IODELAY_EYE_SCAN_ERRMAP_EN
            errmap_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ch_q        <= ch_d;
            tap_q       <= tap_d;
            err_q       <= err_d;
            map_q       <= map_d;
            value_q     <= value_d;
            update_q    <= update_d;
            win_tap_q   <= win_tap_d;
            win_len_q   <= win_len_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rv_q        <= rv_d;
            res_ch_q    <= res_ch_d;
            res_tap_q   <= res_tap_d;
            res_width_q <= res_width_d;
            fail_q      <= fail_d;
`ifdef IODELAY_EYE_SCAN_ERRMAP_EN
            errmap_q    <= errmap_d;
`endif
        end
    end

    assign dly_io.delay_channel = ch_q;
    assign dly_io.delay_value   = value_q;
    assign dly_io.delay_update  = update_q;
    assign busy_o               = busy_q;
    assign done_o               = done_q;
    assign result_valid_o       = rv_q;
    assign result_channel_o     = res_ch_q;
    assign result_tap_o         = res_tap_q;
    assign result_width_o       = res_width_q;
    assign fail_o               = fail_q;
`ifdef IODELAY_EYE_SCAN_ERRMAP_EN
    assign errmap_o             = errmap_q;
`endif

endmodule

// File: tb/tb_iodelay_eye_scan.sv
// Self-checking bench for iodelay_eye_scan: a behavioural delay block returns data whose
// error pattern depends on the loaded tap, and each reported window is compared with a
// brute-force search over all (start, length) tap intervals.
module tb_iodelay_eye_scan;
    localparam int unsigned NCH = 3;
    localparam int unsigned S   = 3;
    localparam int unsigned N   = 4;
    // Per tap: LOAD(2) + SETTLE + SAMPLE + EVAL(1).
    localparam int TAP_CYC  = 3 + S + N;
    // Per channel: 32 taps + SET_CENTER(2) + CENTER_WAIT + NEXT_CH(1).
    localparam int SCAN_CYC = NCH * (32 * TAP_CYC + 3 + S);

    logic clk = 1'b0;
    logic reset;
    logic start;
    always #5 clk = ~clk;

    iodelay_eye_scan_if #(.NINPUT(NCH)) dly ();

    logic           busy, done, rv;
    logic [7:0]     rch;
    logic [4:0]     rtap;
    logic [5:0]     rwid;
    logic [NCH-1:0] fail;
`ifdef IODELAY_EYE_SCAN_ERRMAP_EN
    logic [31:0]    errmap;
`endif

    iodelay_eye_scan #(
        .NINPUT       (NCH),
        .SETTLE_CYCLES(S),
        .SAMPLE_CYCLES(N)
    ) dut (
        .clk_i           (clk),
        .reset_i         (reset),
        .start_i         (start),
        .dly_io          (dly),
        .busy_o          (busy),
        .done_o          (done),
        .result_valid_o  (rv),
        .result_channel_o(rch),
        .result_tap_o    (rtap),
        .result_width_o  (rwid),
`ifdef IODELAY_EYE_SCAN_ERRMAP_EN
        .errmap_o        (errmap),
`endif
        .fail_o          (fail)
    );

    int vectors = 0;
    int errors  = 0;

    // glitch_at[c][t] < 0: tap good; otherwise the sample-window offset of a single mismatch.
    int             glitch_at[NCH][32];
    int             loaded_tap[NCH];
    logic           prev_upd = 1'b0;
    int             high_run = 0;
    int             since_fall = 1000;
    logic [7:0]     rec_ch = '0;
    logic [4:0]     rec_val = '0;
    int             exp_ch, rv_cnt, done_cnt, busy_cnt, rise_cnt;
    logic [NCH-1:0] exp_fail;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] good_map(input int c);
        logic [31:0] m;
        for (int t = 0; t < 32; t++) m[t] = (glitch_at[c][t] < 0);
        return m;
    endfunction

    // Brute force over every interval; strict '>' with ascending start keeps the lowest start.
    function automatic void window(input logic [31:0] m, output int tap, output int width);
        logic [63:0] mask;
        tap   = 0;
        width = 0;
        for (int s = 0; s < 32; s++) begin
            for (int l = 1; l <= 32 - s; l++) begin
                mask = ((64'd1 << l) - 64'd1) << s;
                if ((64'(m) & mask) == mask && l > width) begin
                    width = l;
                    tap   = s + (l - 1) / 2;
                end
            end
        end
    endfunction

    task automatic set_all_bad(input int c);
        for (int t = 0; t < 32; t++) glitch_at[c][t] = int'($urandom_range(N - 1));
    endtask

    task automatic set_good(input int c, input int lo, input int hi);
        for (int t = lo; t <= hi; t++) glitch_at[c][t] = -1;
    endtask

    task automatic set_random(input int c);
        int p;
        p = int'($urandom_range(100));
        for (int t = 0; t < 32; t++)
            glitch_at[c][t] = (int'($urandom_range(99)) < p) ? -1 : int'($urandom_range(N - 1));
    endtask

    // One clock cycle: observe outputs at the falling edge, model the delay block, drive data.
    task automatic step();
        logic [NCH-1:0] e, d;
        int             t, w;
        @(negedge clk);
        if (dly.delay_update) begin
            if (!prev_upd) begin
                rec_ch   = dly.delay_channel;
                rec_val  = dly.delay_value;
                high_run = 0;
                rise_cnt++;
                if (rec_ch < NCH) loaded_tap[rec_ch] = int'(rec_val);
            end else begin
                check("strobe_ch_stable", dly.delay_channel, rec_ch);
                check("strobe_val_stable", dly.delay_value, rec_val);
            end
            high_run++;
        end else begin
            if (prev_upd) begin
                check("strobe_len", high_run, 2);
                since_fall = 0;
            end else if (since_fall < 1000) begin
                since_fall++;
            end
            if (since_fall < S) begin
                check("settle_ch_stable", dly.delay_channel, rec_ch);
                check("settle_val_stable", dly.delay_value, rec_val);
            end
        end
        prev_upd = dly.delay_update;

        if (rv) begin
            check("rv_in_range", exp_ch < NCH, 1);
            if (exp_ch < NCH) begin
                window(good_map(exp_ch), t, w);
                check("res_channel", rch, exp_ch);
                check("res_tap", rtap, t);
                check("res_width", rwid, w);
                check("center_loaded", loaded_tap[exp_ch], t);
`ifdef IODELAY_EYE_SCAN_ERRMAP_EN
                check("errmap", errmap, good_map(exp_ch));
`endif
                if (w == 0) exp_fail[exp_ch] = 1'b1;
            end
            exp_ch++;
            rv_cnt++;
        end
        if (done) done_cnt++;
        if (busy) busy_cnt++;

        // Inside the sample window the error pattern follows the loaded tap; outside it is noise.
        for (int c = 0; c < NCH; c++) begin
            e[c] = 1'($urandom);
            if (since_fall >= S && since_fall < S + N)
                d[c] = e[c] ^ (glitch_at[c][loaded_tap[c]] == since_fall - int'(S));
            else
                d[c] = 1'($urandom);
        end
        dly.expect_in = e;
        dly.data_in   = d;
    endtask

    task automatic clear_scan_counts();
        exp_ch   = 0;
        rv_cnt   = 0;
        done_cnt = 0;
        busy_cnt = 0;
        rise_cnt = 0;
        exp_fail = '0;
    endtask

    task automatic finish_scan(input int budget);
        int cyc;
        cyc = 0;
        while (done_cnt == 0 && cyc < budget) begin
            step();
            cyc++;
        end
        check("scan_done_seen", done_cnt, 1);
        check("result_count", rv_cnt, NCH);
        check("fail_flags", fail, exp_fail);
        step();
        check("done_single_pulse", done, 0);
        check("busy_dropped", busy, 0);
        check("result_hold_ch", rch, NCH - 1);
    endtask

    task automatic run_scan(input bit hold_start, input bit poke);
        int cyc;
        clear_scan_counts();
        start = 1'b1;
        step();
        if (!hold_start) start = 1'b0;
        cyc = 0;
        while (done_cnt == 0 && cyc < SCAN_CYC + 20) begin
            step();
            cyc++;
            if (poke) start = (cyc == 100);
        end
        check("busy_cycles", busy_cnt, SCAN_CYC);
        check("load_strobes", rise_cnt, NCH * 33);
        finish_scan(5);
    endtask

    initial begin
        bit found;
        for (int c = 0; c < NCH; c++) loaded_tap[c] = 0;
        clear_scan_counts();
        reset         = 1'b1;
        start         = 1'b0;
        dly.data_in   = '0;
        dly.expect_in = '0;
        repeat (3) step();
        reset = 1'b0;
        step();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rv", rv, 0);
        check("rst_update", dly.delay_update, 0);
        check("rst_channel", dly.delay_channel, 0);
        check("rst_value", dly.delay_value, 0);
        check("rst_res", {rch, rtap, rwid}, 0);
        check("rst_fail", fail, 0);
`ifdef IODELAY_EYE_SCAN_ERRMAP_EN
        check("rst_errmap", errmap, 0);
`endif

        // Reference windows plus a START pulse while busy.
        set_all_bad(0); set_good(0, 10, 19);
        set_all_bad(1); set_good(1, 3, 4);
        set_random(2);
        run_scan(0, 1);

        // All bad, tied windows, all good.
        set_all_bad(0);
        set_all_bad(1); set_good(1, 2, 5); set_good(1, 20, 23);
        set_all_bad(2); set_good(2, 0, 31);
        run_scan(0, 0);

        // Single mismatch on the last / first sample cycle of one tap.
        set_all_bad(0); set_good(0, 0, 31); glitch_at[0][7] = N - 1;
        set_all_bad(1); set_good(1, 0, 31); glitch_at[1][20] = 0;
        set_random(2);
        run_scan(0, 0);

        repeat (3) begin
            for (int c = 0; c < NCH; c++) set_random(c);
            run_scan(0, 0);
        end

        // START held across DONE starts a new scan; reset aborts it at ch1 tap 12 mid-sample.
        set_all_bad(0);
        set_random(1); set_good(1, 12, 12);
        set_random(2);
        run_scan(1, 0);
        step();
        check("restart_after_done", busy, 1);
        start = 1'b0;
        clear_scan_counts();
        found = 1'b0;
        for (int i = 0; i < SCAN_CYC && !found; i++) begin
            step();
            found = (dly.delay_channel == 8'd1) && (loaded_tap[1] == 12) && !dly.delay_update
                && (since_fall >= S) && (since_fall < S + N);
        end
        check("reached_ch1_tap12", found, 1);
        reset = 1'b1;
        step();
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_rv", rv, 0);
        check("abort_update", dly.delay_update, 0);
        check("abort_channel", dly.delay_channel, 0);
        check("abort_value", dly.delay_value, 0);
        check("abort_res", {rch, rtap, rwid}, 0);
        check("abort_fail", fail, 0);
        reset    = 1'b0;
        rise_cnt = 0;
        repeat (40) step();
        check("no_strobe_after_reset", rise_cnt, 0);
        check("tap_left_loaded", loaded_tap[1], 12);
        check("idle_after_reset", busy, 0);
        run_scan(0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
